// File: rtl/risc_acc_core.sv
// Eight-phase accumulator CPU with a host-programmable unified memory.
// The host port writes memory only while stopped; reads are always combinational.
module risc_acc_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_wdata,
  output logic [DATA_WIDTH-1:0] prog_rdata,
  output logic [ADDR_WIDTH-1:0] pc_counter,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic                  carry,
  output logic [2:0]            phase,
  output logic                  busy,
  output logic                  halt,
  output logic                  instr_done
);

  if (DATA_WIDTH < ADDR_WIDTH + 3) begin : g_bad_width
    $error("risc_acc_core: DATA_WIDTH must be at least ADDR_WIDTH+3");
  end

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_STOP, ST_RUN} state_t;
  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state, w_state_nxt;
  logic [2:0]            r_phase, w_phase_nxt;
  logic                  r_halt, w_halt_nxt, w_instr_done;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_acc, r_mdr;
  logic                  r_carry;
  opcode_t               r_ir_op;
  logic [ADDR_WIDTH-1:0] r_ir_opd;
  logic [DATA_WIDTH-1:0] w_fetch;

  // IR keeps only opcode and operand; bits between them carry no meaning.
  assign w_fetch = r_mem[r_pc];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_STOP;
      r_phase <= 3'd0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_halt  <= w_halt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_halt_nxt   = r_halt;
    w_instr_done = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = 3'd0;
          w_halt_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        w_phase_nxt = r_phase + 3'd1;
        if (r_phase == 3'd3 && r_ir_op == OP_HLT) begin
          w_state_nxt  = ST_STOP;
          w_phase_nxt  = 3'd0;
          w_halt_nxt   = 1'b1;
          w_instr_done = 1'b1;
        end else if (r_phase == 3'd7) begin
          w_instr_done = 1'b1;
          if (step_mode) w_state_nxt = ST_STOP;
        end
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_mdr    <= '0;
      r_ir_op  <= OP_HLT;
      r_ir_opd <= '0;
    end else if (r_state == ST_RUN) begin
      case (r_phase)
        3'd1: begin
          r_ir_op  <= opcode_t'(w_fetch[DATA_WIDTH-1:DATA_WIDTH-3]);
          r_ir_opd <= w_fetch[ADDR_WIDTH-1:0];
        end
        3'd2: r_pc  <= r_pc + 1'b1;
        3'd5: r_mdr <= r_mem[r_ir_opd];
        3'd6: begin
          case (r_ir_op)
            OP_SKZ: if (r_acc == '0) r_pc <= r_pc + 1'b1;
            OP_ADD: {r_carry, r_acc} <= {1'b0, r_acc} + {1'b0, r_mdr};
            OP_AND: begin r_acc <= r_acc & r_mdr; r_carry <= 1'b0; end
            OP_XOR: begin r_acc <= r_acc ^ r_mdr; r_carry <= 1'b0; end
            OP_LDA: begin r_acc <= r_mdr;         r_carry <= 1'b0; end
            OP_JMP: r_pc <= r_ir_opd;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Memory is not reset; host writes and STO can never coincide since they need different states.
  always_ff @(posedge clk) begin
    if (r_state == ST_STOP && prog_we)
      r_mem[prog_addr] <= prog_wdata;
    else if (r_state == ST_RUN && r_phase == 3'd7 && r_ir_op == OP_STO)
      r_mem[r_ir_opd] <= r_acc;
  end

  assign prog_rdata = r_mem[prog_addr];
  assign pc_counter = r_pc;
  assign acc_out    = r_acc;
  assign carry      = r_carry;
  assign phase      = r_phase;
  assign busy       = (r_state == ST_RUN);
  assign halt       = r_halt;
  assign instr_done = w_instr_done;

endmodule

// File: tb/tb_risc_acc_core.sv
// Scenario bench for risc_acc_core: an instruction-level model pushes expected
// {pc, acc, carry} per instruction; each instr_done pulse pops and compares.
module tb_risc_acc_core;
  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, step_mode = 1'b0, prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_wdata = '0;
  logic [DW-1:0] prog_rdata, acc_out;
  logic [AW-1:0] pc_counter;
  logic [2:0]    phase;
  logic          carry, busy, halt, instr_done;

  risc_acc_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_rdata(prog_rdata), .pc_counter(pc_counter), .acc_out(acc_out),
    .carry(carry), .phase(phase), .busy(busy), .halt(halt), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_mem [32];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  logic          m_c;
  int            n_chk = 0, n_fail = 0;

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk); prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk); prog_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic do_reset(input logic sm);
    @(negedge clk); rst = 1'b1; step_mode = sm;
    @(negedge clk); rst = 1'b0;
    m_pc = '0; m_acc = '0; m_c = 1'b0;
  endtask

  // Instruction-level reference: runs n instructions or up to and including a HLT.
  task automatic model_exec(input int n);
    logic [DW-1:0] w;
    logic [AW-1:0] a;
    logic [DW:0]   s;
    for (int k = 0; k < n; k++) begin
      w = m_mem[m_pc]; a = w[AW-1:0]; m_pc = m_pc + 1'b1;
      case (w[DW-1:DW-3])
        3'b001: if (m_acc == '0) m_pc = m_pc + 1'b1;
        3'b010: begin s = {1'b0, m_acc} + {1'b0, m_mem[a]}; m_acc = s[DW-1:0]; m_c = s[DW]; end
        3'b011: begin m_acc = m_acc & m_mem[a]; m_c = 1'b0; end
        3'b100: begin m_acc = m_acc ^ m_mem[a]; m_c = 1'b0; end
        3'b101: begin m_acc = m_mem[a]; m_c = 1'b0; end
        3'b110: m_mem[a] = m_acc;
        3'b111: m_pc = a;
        default: ;
      endcase
      sb.push_back({m_pc, m_acc, m_c});
      if (w[DW-1:DW-3] == 3'b000) break;
    end
  endtask

  // Pulse start (optionally with a same-edge host write), then score every instr_done
  // until busy drops. poke drives a host write to wa/wd while the core is running.
  task automatic run(input int budget, input logic wr, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic poke, output int cyc);
    exp_t e;
    @(negedge clk); start = 1'b1;
    if (wr) begin prog_we = 1'b1; prog_addr = wa; prog_wdata = wd; end
    @(negedge clk); start = 1'b0; prog_we = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || halt !== 1'b0 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b halt=%b phase=%0d, want busy=1 halt=0 phase=0", busy, halt, phase);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < budget) begin
      if (instr_done === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_instr_done: pc=%0d, no instruction expected", pc_counter);
        end else begin
          e = sb.pop_front();
          if ({pc_counter, acc_out, carry} !== e) begin
            n_fail++;
            $display("FAIL instr_result: pc=%0d acc=%h c=%b, want pc=%0d acc=%h c=%b",
                     pc_counter, acc_out, carry, e.pc, e.acc, e.c);
          end
        end
      end
      if (poke && cyc == 3) begin prog_we = 1'b1; prog_addr = wa; prog_wdata = wd; end
      if (poke && cyc == 5) prog_we = 1'b0;
      @(negedge clk); cyc++;
    end
    prog_we = 1'b0;
    n_chk++;
    if (cyc >= budget || sb.size() != 0) begin
      n_fail++;
      $display("FAIL run_end: cycles=%0d pending=%0d, want stop within %0d with 0 pending", cyc, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if (pc_counter !== '0 || acc_out !== '0 || carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%0d acc=%h c=%b, want 0 0 0", pc_counter, acc_out, carry);
    end
    n_chk++;
    if (phase !== 3'd0 || busy !== 1'b0 || halt !== 1'b0 || instr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: phase=%0d busy=%b halt=%b done=%b, want 0 0 0 0", phase, busy, halt, instr_done);
    end
    @(negedge clk); rst = 1'b0;
    m_pc = '0; m_acc = '0; m_c = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_arith();
    int cyc;
    do_reset(1'b0);
    host_wr(0, 8'hB4); host_wr(1, 8'h55); host_wr(2, 8'hD6); host_wr(3, 8'h00);
    host_wr(20, 8'hF0); host_wr(21, 8'h20); host_wr(22, 8'h00);
    model_exec(16);
    run(64, 1'b0, '0, '0, 1'b0, cyc);
    n_chk++;
    if (cyc !== 28 || halt !== 1'b1 || pc_counter !== 5'd4) begin
      n_fail++;
      $display("FAIL arith_halt: cycles=%0d halt=%b pc=%0d, want 28 1 4", cyc, halt, pc_counter);
    end
    n_chk++;
    if (acc_out !== 8'h10 || carry !== 1'b1) begin
      n_fail++;
      $display("FAIL arith_acc: acc=%h c=%b, want 10 1", acc_out, carry);
    end
    prog_addr = 5'd22; #1;
    n_chk++;
    if (prog_rdata !== 8'h10) begin
      n_fail++;
      $display("FAIL arith_store: mem22=%h, want 10", prog_rdata);
    end
  endtask

  task automatic test_skz();
    int cyc;
    do_reset(1'b0);
    host_wr(0, 8'hA0); host_wr(1, 8'h9F); host_wr(2, 8'h20); host_wr(3, 8'hB4);
    host_wr(4, 8'h00); host_wr(5, 8'hB4); host_wr(6, 8'h20); host_wr(7, 8'h00);
    host_wr(20, 8'h55); host_wr(31, 8'hA0);
    model_exec(16);
    run(64, 1'b0, '0, '0, 1'b0, cyc);
    n_chk++;
    if (pc_counter !== 5'd5 || acc_out !== 8'h00 || halt !== 1'b1) begin
      n_fail++;
      $display("FAIL skz_taken: pc=%0d acc=%h halt=%b, want 5 00 1", pc_counter, acc_out, halt);
    end
    model_exec(16);
    run(64, 1'b0, '0, '0, 1'b0, cyc);
    n_chk++;
    if (pc_counter !== 5'd8 || acc_out !== 8'h55 || halt !== 1'b1) begin
      n_fail++;
      $display("FAIL skz_not_taken: pc=%0d acc=%h halt=%b, want 8 55 1", pc_counter, acc_out, halt);
    end
  endtask

  task automatic test_jump_wrap();
    int cyc;
    do_reset(1'b0);
    host_wr(0, 8'hFF); host_wr(31, 8'hE2); host_wr(2, 8'h00);
    model_exec(16);
    run(64, 1'b0, '0, '0, 1'b0, cyc);
    n_chk++;
    if (pc_counter !== 5'd3 || halt !== 1'b1) begin
      n_fail++;
      $display("FAIL jump: pc=%0d halt=%b, want 3 1", pc_counter, halt);
    end
    do_reset(1'b1);
    host_wr(31, 8'hB5);
    model_exec(1);
    run(32, 1'b0, '0, '0, 1'b0, cyc);
    model_exec(1);
    run(32, 1'b0, '0, '0, 1'b0, cyc);
    n_chk++;
    if (pc_counter !== 5'd0 || acc_out !== 8'h20) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%0d acc=%h, want 0 20", pc_counter, acc_out);
    end
  endtask

  task automatic test_step();
    int cyc;
    int            exp_cyc [3] = '{8, 8, 4};
    logic [AW-1:0] exp_pc  [3] = '{5'd1, 5'd2, 5'd3};
    logic          exp_h   [3] = '{1'b0, 1'b0, 1'b1};
    do_reset(1'b1);
    host_wr(0, 8'hB4); host_wr(1, 8'h55); host_wr(2, 8'h00);
    host_wr(20, 8'hF0); host_wr(21, 8'h20);
    for (int i = 0; i < 3; i++) begin
      model_exec(1);
      run(32, 1'b0, '0, '0, 1'b0, cyc);
      n_chk++;
      if (cyc !== exp_cyc[i] || pc_counter !== exp_pc[i] || halt !== exp_h[i]) begin
        n_fail++;
        $display("FAIL step_%0d: cycles=%0d pc=%0d halt=%b, want %0d %0d %b",
                 i, cyc, pc_counter, halt, exp_cyc[i], exp_pc[i], exp_h[i]);
      end
    end
    step_mode = 1'b0;
  endtask

  task automatic test_write_start();
    int cyc;
    do_reset(1'b0);
    host_wr(0, 8'h00); host_wr(1, 8'h00);
    m_mem[0] = 8'hB4;
    model_exec(8);
    run(64, 1'b1, 5'd0, 8'hB4, 1'b0, cyc);
    n_chk++;
    if (acc_out !== 8'hF0 || pc_counter !== 5'd2) begin
      n_fail++;
      $display("FAIL write_with_start: acc=%h pc=%0d, want F0 2", acc_out, pc_counter);
    end
  endtask

  task automatic test_self_mod();
    int cyc;
    do_reset(1'b0);
    host_wr(0, 8'hB4); host_wr(1, 8'hC2); host_wr(2, 8'h00); host_wr(3, 8'h00);
    host_wr(20, 8'hB5); host_wr(21, 8'h20);
    model_exec(8);
    run(64, 1'b0, '0, '0, 1'b0, cyc);
    n_chk++;
    if (acc_out !== 8'h20 || pc_counter !== 5'd4) begin
      n_fail++;
      $display("FAIL self_modify: acc=%h pc=%0d, want 20 4", acc_out, pc_counter);
    end
  endtask

  task automatic test_guards();
    int cyc;
    int k;
    do_reset(1'b0);
    host_wr(25, 8'h11); host_wr(0, 8'hB4); host_wr(1, 8'h55); host_wr(2, 8'h00);
    host_wr(20, 8'hF0); host_wr(21, 8'h20);
    model_exec(8);
    run(64, 1'b0, 5'd25, 8'h77, 1'b1, cyc);
    prog_addr = 5'd25; #1;
    n_chk++;
    if (prog_rdata !== 8'h11) begin
      n_fail++;
      $display("FAIL busy_write_ignored: mem25=%h, want 11", prog_rdata);
    end
    do_reset(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(phase == 3'd5 && pc_counter == 5'd2) && k < 40) begin
      @(negedge clk); k++;
    end
    n_chk++;
    if (k >= 40) begin
      n_fail++;
      $display("FAIL reach_phase5: waited %0d cycles, want phase 5 at pc 2", k);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (pc_counter !== '0 || acc_out !== '0 || busy !== 1'b0 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%0d acc=%h busy=%b phase=%0d, want 0 00 0 0",
               pc_counter, acc_out, busy, phase);
    end
    @(negedge clk); rst = 1'b0;
    m_pc = '0; m_acc = '0; m_c = 1'b0;
    prog_addr = 5'd20; #1;
    n_chk++;
    if (prog_rdata !== 8'hF0) begin
      n_fail++;
      $display("FAIL mem_kept_20: mem20=%h, want F0", prog_rdata);
    end
    prog_addr = 5'd0; #1;
    n_chk++;
    if (prog_rdata !== 8'hB4) begin
      n_fail++;
      $display("FAIL mem_kept_0: mem0=%h, want B4", prog_rdata);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    for (int a = 0; a < 32; a++) host_wr(a[AW-1:0], 8'h00);
    test_arith();
    test_skz();
    test_jump_wrap();
    test_step();
    test_write_start();
    test_self_mod();
    test_guards();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risc_acc_core.md
RISC_ACC_CORE -- requirements
Module: risc_acc_core

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: accumulator, memory word and instruction width.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 5: PC/operand width.
  - Memory depth is 2**ADDR_WIDTH words.
  - DATA_WIDTH >= ADDR_WIDTH+3 is required; elaboration SHALL fail otherwise.
- REQ-003 SHALL have `clk`, input, 1: single clock; all state changes on its rising edge.
- REQ-004 SHALL have `rst`, input, 1: asynchronous, active-high reset.
- REQ-005 SHALL have `start`, input, 1: begin or resume execution from the current PC while stopped.
- REQ-006 SHALL have `step_mode`, input, 1: when 1, stop after each completed instruction.
- REQ-007 SHALL have `prog_we`, input, 1: host memory write strobe.
- REQ-008 SHALL have `prog_addr`, input, ADDR_WIDTH: host memory address.
- REQ-009 SHALL have `prog_wdata`, input, DATA_WIDTH: host memory write data.
- REQ-010 SHALL have `prog_rdata`, output, DATA_WIDTH: combinational mem[prog_addr].
- REQ-011 SHALL have `pc_counter`, output, ADDR_WIDTH: program counter.
- REQ-012 SHALL have `acc_out`, output, DATA_WIDTH: accumulator.
- REQ-013 SHALL have `carry`, output, 1: carry flag.
- REQ-014 SHALL have `phase`, output, 3: current instruction phase, 0-7.
- REQ-015 SHALL have `busy`, output, 1: core is in RUN.
- REQ-016 SHALL have `halt`, output, 1: stopped by a HLT instruction.
- REQ-017 SHALL have `instr_done`, output, 1: one-cycle pulse on the final phase of each instruction.

Function
- REQ-018 Run FSM SHALL have two states, STOP and RUN.
  - STOP with start=1 SHALL go to RUN with phase=0 on the next edge.
  - start SHALL be ignored while in RUN.
- REQ-019 Each instruction SHALL take exactly 8 cycles, phases 0-7.
  - Phase names: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
  - phase SHALL wrap from 7 to 0 while in RUN.
- REQ-020 Instruction format SHALL be: opcode = word[DATA_WIDTH-1:DATA_WIDTH-3]; operand = word[ADDR_WIDTH-1:0]; any bits in between are ignored.
- REQ-021 IR SHALL load mem[pc] at the end of phase 1; PC SHALL increment by 1 modulo 2**ADDR_WIDTH at the end of phase 2.
- REQ-022 Opcodes (operand word mem[operand] is read in phase 5):
  - 000 HLT: at the end of phase 3, go to STOP and set halt=1; PC is unchanged.
  - 001 SKZ: if acc==0, PC SHALL increment again at the end of phase 6.
  - 010 ADD: acc=(acc+mem) modulo 2**DATA_WIDTH; carry=carry-out.
  - 011 AND: acc=acc&mem; carry=0.
  - 100 XOR: acc=acc^mem; carry=0.
  - 101 LDA: acc=mem; carry=0.
  - 110 STO: mem[operand]=acc, written at the end of phase 7.
  - 111 JMP: PC=operand at the end of phase 6.
- REQ-023 acc and carry SHALL update at the end of phase 6; opcodes not listed as updating them SHALL leave them unchanged.
- REQ-024 Host port writes:
  - prog_we SHALL write memory only in STOP; it SHALL be ignored in RUN.
  - A write and a start on the same edge SHALL both take effect, and the first fetch SHALL see the written data.
- REQ-025 Self-modifying code: a STO to the address of the next instruction SHALL be visible to that instruction's fetch.
- REQ-026 If step_mode=1 at the end of phase 7, the core SHALL go to STOP with halt=0 and PC pointing to the next instruction.
- REQ-027 instr_done SHALL be 1 in phase 7 of every completed instruction, and in phase 3 of HLT.
- REQ-028 halt SHALL clear on the edge on which start is accepted.
- REQ-029 busy SHALL equal (state==RUN).

Reset
- REQ-030 rst=1 SHALL force, immediately and regardless of phase:
  - state=STOP, phase=0, pc_counter=0, acc_out=0, carry=0, IR=0;
  - busy=0, halt=0, instr_done=0.
- REQ-031 rst SHALL NOT clear memory contents.
- REQ-032 Release of rst SHALL NOT start execution; start is required.

Verification
Parameters for all scenarios: DATA_WIDTH=8, ADDR_WIDTH=5.
- REQ-033 Arithmetic program: mem[0..3]=0xB4,0x55,0xD6,0x00; mem[20]=0xF0, mem[21]=0x20; pulse start.
  - Required: acc=0x10, carry=1, mem[22]=0x10 (checked via prog_rdata).
  - Required: halt=1 on the 28th cycle after start, with pc_counter=4.
- REQ-034 SKZ: mem[0]=0xA0 (LDA 0, acc=0xA0), XOR with mem[31]=0xA0 giving acc=0, then SKZ.
  - Required: the instruction after SKZ is skipped and PC advances by 2.
- REQ-035 Wrap and jump: JMP 31 with mem[31]=0xE2 (JMP 2).
  - Required: PC=31 then 2; separately, a non-jump at address 31 wraps PC to 0.
- REQ-036 Step mode: step_mode=1, 3-instruction program, start pulsed once.
  - Required: busy drops after 8 cycles with pc_counter=1 and halt=0; each further start advances exactly one instruction.
- REQ-037 Guards: prog_we while busy=1 leaves memory unchanged; rst asserted in phase 5 gives pc_counter=0, acc_out=0, busy=0 before the next edge, with memory intact.
